// File: rtl/sisc_ctrl_alu_br.sv
// sisc_ctrl_alu_br -- control-and-compute slice of the SISC multi-cycle CPU.
//   Instruction-sequencing FSM, 32-bit ALU with status flags, and 16-bit
//   branch-target calculator. All outputs are combinational from the state
//   register, instr and stat, so an async reset reaches the outputs at once.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_f     in   asynchronous active-low reset
//   instr     in   IR: opcode[31:28] mm[27:24] rd[23:20] rs[19:16] rt[15:12] imm[15:0]
//   stat      in   registered status {C,V,N,Z}
//   pc_out    in   current PC
//   rega/regb in   register-file read data
//   alu_out   out  ALU result
//   alu_sts   out  ALU status {C,V,N,Z} of current result
//   alu_op    out  selected ALU function
//   br_addr   out  branch target
//   stat_en, rf_we, wb_sel, rb_sel, pc_sel, pc_write, pc_rst, br_sel, ir_load
//             out  datapath enables / selects
//
// state      | meaning
// -----------+-------------------------------------------------
// START0     | first reset cycle, PC held clear
// START1     | second reset cycle, PC held clear
// FETCH      | load IR, PC <= PC+1
// DECODE     | redirect PC on a taken branch; HLT goes to HALT
// EXECUTE    | load status register for ALU instructions
// MEM        | idle slot, no enables
// WRITEBACK  | register write for ALU instructions
// HALT       | stopped until reset

module sisc_ctrl_alu_br (
  input  logic        clk,
  input  logic        rst_f,
  input  logic [31:0] instr,
  input  logic [3:0]  stat,
  input  logic [15:0] pc_out,
  input  logic [31:0] rega,
  input  logic [31:0] regb,
  output logic [31:0] alu_out,
  output logic [3:0]  alu_sts,
  output logic        stat_en,
  output logic [1:0]  alu_op,
  output logic [15:0] br_addr,
  output logic        rf_we,
  output logic        wb_sel,
  output logic        rb_sel,
  output logic        pc_sel,
  output logic        pc_write,
  output logic        pc_rst,
  output logic        br_sel,
  output logic        ir_load
);

  typedef enum logic [2:0] {
    S_START0    = 3'd0,
    S_START1    = 3'd1,
    S_FETCH     = 3'd2,
    S_DECODE    = 3'd3,
    S_EXECUTE   = 3'd4,
    S_MEM       = 3'd5,
    S_WRITEBACK = 3'd6,
    S_HALT      = 3'd7
  } state_t;

  localparam logic [3:0] OP_ALU = 4'b0001;
  localparam logic [3:0] OP_BRA = 4'b0010;
  localparam logic [3:0] OP_BRR = 4'b0011;
  localparam logic [3:0] OP_BNE = 4'b0100;
  localparam logic [3:0] OP_BNR = 4'b0101;
  localparam logic [3:0] OP_HLT = 4'b1111;

  state_t state_q, state_d;

  logic [3:0]  opcode;
  logic [3:0]  mm;
  logic [15:0] imm;
  logic        is_alu;
  logic        br_taken;

  assign opcode = instr[31:28];
  assign mm     = instr[27:24];
  assign imm    = instr[15:0];
  assign is_alu = (opcode == OP_ALU);

  // ---------------- branch condition and target ----------------
  always_comb begin
    br_taken = 1'b0;
    case (opcode)
      OP_BRA, OP_BRR: br_taken = |(mm & stat);
      OP_BNE, OP_BNR: br_taken = ~|(mm & stat);
      default:        br_taken = 1'b0;
    endcase
  end

  assign br_sel  = (opcode == OP_BRA) || (opcode == OP_BNE);
  // pc_out has already been incremented by the time DECODE evaluates this.
  assign br_addr = br_sel ? imm : (pc_out + imm);

  // ---------------- ALU ----------------
  logic [31:0] opnd_b;
  logic        carry_in;
  logic [32:0] sum;
  logic        is_and;

  assign alu_op = is_alu ? mm[1:0] : 2'b00;
  assign is_and = (alu_op == 2'b11);

  always_comb begin
    opnd_b   = regb;
    carry_in = 1'b0;
    case (alu_op)
      2'b00: begin opnd_b = regb;                    carry_in = 1'b0; end
      2'b01: begin opnd_b = {{16{imm[15]}}, imm};    carry_in = 1'b0; end
      2'b10: begin opnd_b = ~regb;                   carry_in = 1'b1; end
      default: begin opnd_b = regb;                  carry_in = 1'b0; end
    endcase
  end

  // Subtract runs through the same adder as a + ~b + 1, so carry-out
  // doubles as "no borrow" and the overflow rule is shared with add.
  assign sum     = {1'b0, rega} + {1'b0, opnd_b} + {32'b0, carry_in};
  assign alu_out = is_and ? (rega & regb) : sum[31:0];

  always_comb begin
    alu_sts[3] = is_and ? 1'b0 : sum[32];
    alu_sts[2] = is_and ? 1'b0 :
                 ((rega[31] == opnd_b[31]) && (sum[31] != rega[31]));
    alu_sts[1] = alu_out[31];
    alu_sts[0] = (alu_out == 32'b0);
  end

  // ---------------- sequencing FSM ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_START0:    state_d = S_START1;
      S_START1:    state_d = S_FETCH;
      S_FETCH:     state_d = S_DECODE;
      S_DECODE:    state_d = (opcode == OP_HLT) ? S_HALT : S_EXECUTE;
      S_EXECUTE:   state_d = S_MEM;
      S_MEM:       state_d = S_WRITEBACK;
      S_WRITEBACK: state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_START0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) state_q <= S_START0;
    else        state_q <= state_d;
  end

  always_comb begin
    stat_en  = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    rb_sel   = 1'b0;
    pc_sel   = 1'b0;
    pc_write = 1'b0;
    pc_rst   = 1'b0;
    ir_load  = 1'b0;
    case (state_q)
      S_START0, S_START1: pc_rst = 1'b1;
      S_FETCH: begin
        ir_load  = 1'b1;
        pc_write = 1'b1;
      end
      S_DECODE: begin
        pc_write = br_taken;
        pc_sel   = br_taken;
      end
      S_EXECUTE:   stat_en = is_alu;
      S_WRITEBACK: rf_we   = is_alu;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sisc_ctrl_alu_br.sv
// tb_sisc_ctrl_alu_br -- directed self-checking bench for sisc_ctrl_alu_br.
//   Walks reset, ALU ops, non-ALU opcodes, branches, halt and a reset
//   taken in the middle of an instruction. Control outputs are compared as
//   one packed vector {stat_en,rf_we,wb_sel,rb_sel,pc_sel,pc_write,pc_rst,ir_load}.

module tb_sisc_ctrl_alu_br;

  logic        clk;
  logic        rst_f;
  logic [31:0] instr;
  logic [3:0]  stat;
  logic [15:0] pc_out;
  logic [31:0] rega, regb;
  logic [31:0] alu_out;
  logic [3:0]  alu_sts;
  logic        stat_en, rf_we, wb_sel, rb_sel, pc_sel, pc_write, pc_rst, br_sel, ir_load;
  logic [1:0]  alu_op;
  logic [15:0] br_addr;
  logic [7:0]  ctl;

  int errors = 0;
  int checks = 0;

  sisc_ctrl_alu_br dut (
    .clk(clk), .rst_f(rst_f), .instr(instr), .stat(stat), .pc_out(pc_out),
    .rega(rega), .regb(regb), .alu_out(alu_out), .alu_sts(alu_sts),
    .stat_en(stat_en), .alu_op(alu_op), .br_addr(br_addr), .rf_we(rf_we),
    .wb_sel(wb_sel), .rb_sel(rb_sel), .pc_sel(pc_sel), .pc_write(pc_write),
    .pc_rst(pc_rst), .br_sel(br_sel), .ir_load(ir_load)
  );

  assign ctl = {stat_en, rf_we, wb_sel, rb_sel, pc_sel, pc_write, pc_rst, ir_load};

  localparam logic [7:0] C_START = 8'h02;
  localparam logic [7:0] C_FETCH = 8'h05;
  localparam logic [7:0] C_TAKEN = 8'h0C;
  localparam logic [7:0] C_EXALU = 8'h80;
  localparam logic [7:0] C_WBALU = 8'h40;
  localparam logic [7:0] C_IDLE  = 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] ins, a, b, res;
    logic [3:0]  sts;
    logic [1:0]  op;
    logic [7:0]  ex, wb;
  } alu_vec_t;

  typedef struct {
    logic [31:0] ins;
    logic [3:0]  st;
    logic [15:0] pc, addr;
    logic        bsel, taken;
  } br_vec_t;

  task automatic test_reset;
    rst_f = 1'b0; instr = 32'h0; stat = 4'h0; pc_out = 16'h0; rega = 32'h0; regb = 32'h0;
    repeat (2) tick;
    checks++;
    if (ctl !== C_START) begin errors++; $display("FAIL reset_ctl: got %h expected %h", ctl, C_START); end
    checks++;
    if (br_sel !== 1'b0 || alu_op !== 2'b00) begin errors++; $display("FAIL reset_sel: got br_sel=%b alu_op=%b expected 0/00", br_sel, alu_op); end
    rst_f = 1'b1;
    #1;
    checks++;
    if (ctl !== C_START) begin errors++; $display("FAIL start0_ctl: got %h expected %h", ctl, C_START); end
    tick;
    checks++;
    if (ctl !== C_START) begin errors++; $display("FAIL start1_ctl: got %h expected %h", ctl, C_START); end
    tick;
    checks++;
    if (ctl !== C_FETCH) begin errors++; $display("FAIL first_fetch_ctl: got %h expected %h", ctl, C_FETCH); end
  endtask

  // ALU opcodes plus two non-ALU opcodes (NOP, unused 0110) in one table.
  task automatic test_alu;
    alu_vec_t v[8];
    v[0] = '{32'h1000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0110, 2'b00, C_EXALU, C_WBALU};
    v[1] = '{32'h1200_0000, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b1001, 2'b10, C_EXALU, C_WBALU};
    v[2] = '{32'h1100_FFFF, 32'h0000_0010, 32'h1234_5678, 32'h0000_000F, 4'b1000, 2'b01, C_EXALU, C_WBALU};
    v[3] = '{32'h1300_0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b0010, 2'b11, C_EXALU, C_WBALU};
    v[4] = '{32'h1200_0000, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 4'b0010, 2'b10, C_EXALU, C_WBALU};
    v[5] = '{32'h1000_0000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 4'b1101, 2'b00, C_EXALU, C_WBALU};
    v[6] = '{32'h0300_0000, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 4'b0000, 2'b00, C_IDLE,  C_IDLE};
    v[7] = '{32'h6200_0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1001, 2'b00, C_IDLE,  C_IDLE};
    for (int i = 0; i < 8; i++) begin
      instr = v[i].ins; rega = v[i].a; regb = v[i].b; stat = 4'h0; pc_out = 16'h0;
      #1;
      checks++;
      if (ctl !== C_FETCH) begin errors++; $display("FAIL alu_fetch[%0d]: got %h expected %h", i, ctl, C_FETCH); end
      tick;
      checks++;
      if (ctl !== C_IDLE) begin errors++; $display("FAIL alu_decode[%0d]: got %h expected %h", i, ctl, C_IDLE); end
      checks++;
      if (alu_out !== v[i].res) begin errors++; $display("FAIL alu_out[%0d]: got %h expected %h", i, alu_out, v[i].res); end
      checks++;
      if (alu_sts !== v[i].sts) begin errors++; $display("FAIL alu_sts[%0d]: got %b expected %b", i, alu_sts, v[i].sts); end
      checks++;
      if (alu_op !== v[i].op) begin errors++; $display("FAIL alu_op[%0d]: got %b expected %b", i, alu_op, v[i].op); end
      tick;
      checks++;
      if (ctl !== v[i].ex) begin errors++; $display("FAIL alu_execute[%0d]: got %h expected %h", i, ctl, v[i].ex); end
      tick;
      checks++;
      if (ctl !== C_IDLE) begin errors++; $display("FAIL alu_mem[%0d]: got %h expected %h", i, ctl, C_IDLE); end
      tick;
      checks++;
      if (ctl !== v[i].wb) begin errors++; $display("FAIL alu_writeback[%0d]: got %h expected %h", i, ctl, v[i].wb); end
      tick;
    end
  endtask

  task automatic test_branch;
    br_vec_t v[8];
    v[0] = '{32'h2100_0040, 4'b0001, 16'h0010, 16'h0040, 1'b1, 1'b1};
    v[1] = '{32'h5100_0004, 4'b0001, 16'h0010, 16'h0014, 1'b0, 1'b0};
    v[2] = '{32'h3100_FFFE, 4'b0001, 16'h0005, 16'h0003, 1'b0, 1'b1};
    v[3] = '{32'h4200_1234, 4'b0001, 16'h0020, 16'h1234, 1'b1, 1'b1};
    v[4] = '{32'h3800_0003, 4'b0001, 16'hFFFE, 16'h0001, 1'b0, 1'b0};
    v[5] = '{32'h2400_0040, 4'b0001, 16'h0000, 16'h0040, 1'b1, 1'b0};
    v[6] = '{32'h5000_0010, 4'b0000, 16'h0100, 16'h0110, 1'b0, 1'b1};
    v[7] = '{32'h2800_00AA, 4'b1001, 16'h0033, 16'h00AA, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      instr = v[i].ins; stat = v[i].st; pc_out = v[i].pc; rega = 32'h1; regb = 32'h2;
      #1;
      checks++;
      if (ctl !== C_FETCH) begin errors++; $display("FAIL br_fetch[%0d]: got %h expected %h", i, ctl, C_FETCH); end
      tick;
      checks++;
      if (ctl !== (v[i].taken ? C_TAKEN : C_IDLE)) begin
        errors++; $display("FAIL br_decode[%0d]: got %h expected %h", i, ctl, (v[i].taken ? C_TAKEN : C_IDLE));
      end
      checks++;
      if (br_addr !== v[i].addr) begin errors++; $display("FAIL br_addr[%0d]: got %h expected %h", i, br_addr, v[i].addr); end
      checks++;
      if (br_sel !== v[i].bsel) begin errors++; $display("FAIL br_sel[%0d]: got %b expected %b", i, br_sel, v[i].bsel); end
      checks++;
      if (alu_op !== 2'b00) begin errors++; $display("FAIL br_alu_op[%0d]: got %b expected 00", i, alu_op); end
      for (int p = 0; p < 3; p++) begin
        tick;
        checks++;
        if (ctl !== C_IDLE) begin errors++; $display("FAIL br_phase%0d[%0d]: got %h expected %h", p + 2, i, ctl, C_IDLE); end
      end
      tick;
    end
  endtask

  task automatic test_halt;
    int loads;
    int busy;
    instr = 32'hF000_0000; stat = 4'h0; pc_out = 16'h0;
    #1;
    checks++;
    if (ctl !== C_FETCH) begin errors++; $display("FAIL halt_fetch: got %h expected %h", ctl, C_FETCH); end
    tick;
    checks++;
    if (ctl !== C_IDLE) begin errors++; $display("FAIL halt_decode: got %h expected %h", ctl, C_IDLE); end
    loads = 0; busy = 0;
    for (int c = 0; c < 20; c++) begin
      tick;
      if (ir_load) loads++;
      if (ctl !== C_IDLE) busy++;
    end
    checks++;
    if (loads != 0) begin errors++; $display("FAIL halt_ir_load: got %0d loads expected 0", loads); end
    checks++;
    if (busy != 0) begin errors++; $display("FAIL halt_idle: got %0d active cycles expected 0", busy); end
    instr = 32'h0;
    rst_f = 1'b0;
    #1;
    checks++;
    if (ctl !== C_START) begin errors++; $display("FAIL halt_reset: got %h expected %h", ctl, C_START); end
    tick;
    rst_f = 1'b1;
    tick;
    tick;
    checks++;
    if (ctl !== C_FETCH) begin errors++; $display("FAIL halt_refetch: got %h expected %h", ctl, C_FETCH); end
  endtask

  task automatic test_midreset;
    int seen;
    instr = 32'h1000_0000; rega = 32'h7FFF_FFFF; regb = 32'h1; stat = 4'h0;
    #1;
    checks++;
    if (ctl !== C_FETCH) begin errors++; $display("FAIL mid_fetch: got %h expected %h", ctl, C_FETCH); end
    tick;
    tick;
    checks++;
    if (ctl !== C_EXALU) begin errors++; $display("FAIL mid_execute: got %h expected %h", ctl, C_EXALU); end
    #1;
    rst_f = 1'b0;
    #1;
    checks++;
    if (ctl !== C_START) begin errors++; $display("FAIL mid_reset_now: got %h expected %h", ctl, C_START); end
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      tick;
      if (stat_en || rf_we) seen++;
    end
    rst_f = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      if (stat_en || rf_we) seen++;
      tick;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL mid_no_pulse: got %0d stat_en/rf_we samples expected 0", seen); end
    checks++;
    if (ctl !== C_FETCH) begin errors++; $display("FAIL mid_refetch: got %h expected %h", ctl, C_FETCH); end
  endtask

  initial begin
    test_reset;
    test_alu;
    test_branch;
    test_halt;
    test_midreset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
